renamed_register_file: RTL and testbench

Parametrised successor to the two-port architectural register file. Each entry holds either a committed value or, when marked virtual, the rename tag of the in-flight instruction that will produce it. Completing results arrive on common-data-bus (CDB) ports and resolve every entry waiting on their tag. Read ports forward same-cycle CDB results. The block sits between decode/rename (write ports) and the execution units (CDB ports), feeding operand reads to issue.

---
 rtl/renamed_register_file_pkg.sv | 19 +
 rtl/renamed_register_file_cdb_match.sv | 34 +++
 rtl/renamed_register_file.sv | 130 +++++++++++++
 tb/tb_renamed_register_file.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renamed_register_file_pkg.sv
// Shared types for the renamed register file: entry layout, rename tag and width defaults.
package renamed_register_file_pkg;

  localparam int TAG_WIDTH_DEF  = 6;
  localparam int DATA_WIDTH_DEF = 64;

  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

  typedef struct packed {
    logic                      is_virtual;
    logic [DATA_WIDTH_DEF-1:0] data;
  } entry_t;

  // Index width that stays at least one bit for single-port configurations.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/renamed_register_file_cdb_match.sv
// Matches one stored entry against the CDB bus; lowest-index valid port with an equal tag wins.
module renamed_register_file_cdb_match
  import renamed_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int NUM_CDB    = 2,
  localparam int PORT_W    = idx_w(NUM_CDB)
) (
  input  logic                                is_virtual_i,
  input  logic [TAG_WIDTH-1:0]                tag_i,
  input  logic [NUM_CDB-1:0]                  cdb_valid_i,
  input  logic [NUM_CDB-1:0][TAG_WIDTH-1:0]   cdb_tag_i,
  input  logic [NUM_CDB-1:0][DATA_WIDTH-1:0]  cdb_value_i,
  output logic                                hit_o,
  output logic [DATA_WIDTH-1:0]               value_o,
  output logic [PORT_W-1:0]                   port_o
);

  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    port_o  = '0;
    // Walk downwards so the lowest matching index is the last assignment.
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (is_virtual_i && cdb_valid_i[i] && (cdb_tag_i[i] == tag_i)) begin
        hit_o   = 1'b1;
        value_o = cdb_value_i[i];
        port_o  = PORT_W'(i);
      end
    end
  end

endmodule

// File: rtl/renamed_register_file.sv
// Register file whose entries hold a committed value or a pending rename tag resolved by CDB broadcasts.
module renamed_register_file
  import renamed_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int NUM_CDB    = 2,
  parameter int ZERO_REG   = 1,
  localparam int ADDR_W    = $clog2(NUM_REGS),
  localparam int CNT_W     = $clog2(NUM_REGS + 1),
  localparam int PORT_W    = idx_w(NUM_CDB)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WRITE-1:0]                 wr_en,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WRITE-1:0]                 wr_virtual,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_CDB-1:0]                   cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_WIDTH-1:0]    cdb_tag,
  input  logic [NUM_CDB-1:0][DATA_WIDTH-1:0]   cdb_value,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]      rd_addr,
  output logic [NUM_READ-1:0]                  rd_virtual,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [CNT_W-1:0]                     busy_count
);

  logic [NUM_REGS-1:0]   virt_q, virt_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
  logic [CNT_W-1:0]      busy_q, busy_d;

  logic [NUM_REGS-1:0]   ent_hit;
  logic [DATA_WIDTH-1:0] ent_val [NUM_REGS];
  logic [PORT_W-1:0]     ent_port_unused [NUM_REGS];

  for (genvar e = 0; e < NUM_REGS; e++) begin : g_ent
    renamed_register_file_cdb_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .NUM_CDB    (NUM_CDB)
    ) u_match (
      .is_virtual_i (virt_q[e]),
      .tag_i        (data_q[e][TAG_WIDTH-1:0]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_value_i  (cdb_value),
      .hit_o        (ent_hit[e]),
      .value_o      (ent_val[e]),
      .port_o       (ent_port_unused[e])
    );
  end

  // Resolve first, then writes overwrite: a same-cycle rename is younger than the result.
  always_comb begin
    virt_d = virt_q;
    for (int e = 0; e < NUM_REGS; e++) begin
      data_d[e] = data_q[e];
      if (ent_hit[e]) begin
        virt_d[e] = 1'b0;
        data_d[e] = ent_val[e];
      end
      for (int w = NUM_WRITE - 1; w >= 0; w--) begin
        if (wr_en[w] && (wr_addr[w] == ADDR_W'(e))) begin
          virt_d[e] = wr_virtual[w];
          data_d[e] = wr_virtual[w] ? DATA_WIDTH'(wr_data[w][TAG_WIDTH-1:0]) : wr_data[w];
        end
      end
    end
    if (ZERO_REG != 0) begin
      virt_d[0] = 1'b0;
      data_d[0] = '0;
    end
    busy_d = '0;
    for (int e = 0; e < NUM_REGS; e++) begin
      busy_d = busy_d + CNT_W'(virt_d[e]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      virt_q <= '0;
      busy_q <= '0;
      for (int e = 0; e < NUM_REGS; e++) begin
        data_q[e] <= '0;
      end
    end else begin
      virt_q <= virt_d;
      busy_q <= busy_d;
      for (int e = 0; e < NUM_REGS; e++) begin
        data_q[e] <= data_d[e];
      end
    end
  end

  assign busy_count = busy_q;

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic                  sel_virt;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_val;
    logic [PORT_W-1:0]     rd_port_unused;

    assign sel_virt = virt_q[rd_addr[r]];
    assign sel_data = data_q[rd_addr[r]];

    renamed_register_file_cdb_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .NUM_CDB    (NUM_CDB)
    ) u_fwd (
      .is_virtual_i (sel_virt),
      .tag_i        (sel_data[TAG_WIDTH-1:0]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_value_i  (cdb_value),
      .hit_o        (fwd_hit),
      .value_o      (fwd_val),
      .port_o       (rd_port_unused)
    );

    assign rd_virtual[r] = sel_virt & ~fwd_hit;
    assign rd_data[r]    = fwd_hit ? fwd_val : sel_data;
  end

endmodule

// File: tb/tb_renamed_register_file.sv
// Directed bench for renamed_register_file with a per-cycle reference model and literal spot checks.
module tb_renamed_register_file;
  import renamed_register_file_pkg::*;

  localparam int NR = 32;
  localparam int NRD = 2;
  localparam int NW = 2;
  localparam int NC = 2;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int TW = 6;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NW-1:0]           wr_en;
  logic [NW-1:0][AW-1:0]   wr_addr;
  logic [NW-1:0]           wr_virtual;
  logic [NW-1:0][DW-1:0]   wr_data;
  logic [NC-1:0]           cdb_valid;
  logic [NC-1:0][TW-1:0]   cdb_tag;
  logic [NC-1:0][DW-1:0]   cdb_value;
  logic [NRD-1:0][AW-1:0]  rd_addr;
  logic [NRD-1:0]          rd_virtual;
  logic [NRD-1:0][DW-1:0]  rd_data;
  logic [5:0]              busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t model [NR];

  renamed_register_file dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_virtual (wr_virtual),
    .wr_data    (wr_data),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .rd_addr    (rd_addr),
    .rd_virtual (rd_virtual),
    .rd_data    (rd_data),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  // First valid CDB carrying this tag, in port order.
  function automatic bit cdb_lookup(input tag_t t, output logic [63:0] v);
    for (int p = 0; p < NC; p++) begin
      if (cdb_valid[p] && cdb_tag[p] == t) begin
        v = cdb_value[p];
        return 1'b1;
      end
    end
    v = '0;
    return 1'b0;
  endfunction

  function automatic entry_t model_read(input int a);
    entry_t e;
    logic [63:0] v;
    e = model[a];
    if (e.is_virtual && cdb_lookup(tag_t'(e.data), v)) begin
      e.is_virtual = 1'b0;
      e.data = v;
    end
    return e;
  endfunction

  function automatic int model_busy();
    int n = 0;
    for (int a = 0; a < NR; a++) n += model[a].is_virtual;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NR; a++) model[a] = '0;
    end else begin
      entry_t nxt [NR];
      bit claimed [NR];
      logic [63:0] v;
      for (int a = 0; a < NR; a++) begin
        nxt[a] = model[a];
        claimed[a] = 1'b0;
        if (model[a].is_virtual && cdb_lookup(tag_t'(model[a].data), v)) nxt[a] = '{1'b0, v};
      end
      for (int p = 0; p < NW; p++) begin
        int a;
        a = int'(wr_addr[p]);
        if (wr_en[p] && a != 0 && !claimed[a]) begin
          claimed[a] = 1'b1;
          if (wr_virtual[p]) nxt[a] = '{1'b1, {58'd0, wr_data[p][5:0]}};
          else               nxt[a] = '{1'b0, wr_data[p]};
        end
      end
      for (int a = 0; a < NR; a++) model[a] = nxt[a];
    end
  end

  always @(negedge clk) begin
    for (int r = 0; r < NRD; r++) begin
      entry_t e;
      e = model_read(int'(rd_addr[r]));
      check($sformatf("model_rd_virtual[%0d]", r), 64'(rd_virtual[r]), 64'(e.is_virtual));
      check($sformatf("model_rd_data[%0d]", r), rd_data[r], e.data);
    end
    check("model_busy_count", 64'(busy_count), 64'(model_busy()));
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_virtual = '0; wr_data = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic wr(input int p, input int a, input bit v, input logic [63:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = AW'(a); wr_virtual[p] = v; wr_data[p] = d;
  endtask

  task automatic cdb(input int p, input logic [5:0] t, input logic [63:0] v);
    cdb_valid[p] = 1'b1; cdb_tag[p] = t; cdb_value[p] = v;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic chk_rd(input string nm, input int r, input bit ev, input logic [63:0] ed);
    check({nm, "_virt"}, 64'(rd_virtual[r]), 64'(ev));
    check({nm, "_data"}, rd_data[r], ed);
  endtask

  initial begin
    idle();
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    at_neg();
    chk_rd("reset_rd0", 0, 1'b0, 64'h0);
    chk_rd("reset_rd1", 1, 1'b0, 64'h0);
    check("reset_busy", 64'(busy_count), 64'd0);

    // Write priority: both ports to one address, then distinct addresses.
    @(posedge clk); #1;
    wr(0, 7, 1'b0, 64'hAA); wr(1, 7, 1'b0, 64'hBB);
    tick();
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd8;
    at_neg();
    chk_rd("wprio_same_addr", 0, 1'b0, 64'hAA);
    @(posedge clk); #1;
    wr(0, 7, 1'b0, 64'hCC); wr(1, 8, 1'b0, 64'hDD);
    tick();
    at_neg();
    chk_rd("wprio_rd7", 0, 1'b0, 64'hCC);
    chk_rd("wprio_rd8", 1, 1'b0, 64'hDD);

    // Rename then resolve.
    @(posedge clk); #1;
    wr(0, 3, 1'b1, 64'h15);
    rd_addr[0] = 5'd3;
    tick();
    at_neg();
    chk_rd("rename_rd3", 0, 1'b1, 64'h15);
    check("rename_busy", 64'(busy_count), 64'd1);
    @(posedge clk); #1;
    cdb(0, 6'h15, 64'h1234);
    at_neg();
    chk_rd("resolve_fwd_rd3", 0, 1'b0, 64'h1234);
    @(posedge clk); #1;
    idle();
    at_neg();
    chk_rd("resolve_rd3", 0, 1'b0, 64'h1234);
    check("resolve_busy", 64'(busy_count), 64'd0);

    // Multi-entry resolve with forwarding on cdb1, non-matching cdb0.
    @(posedge clk); #1;
    wr(0, 4, 1'b1, 64'h02); wr(1, 9, 1'b1, 64'h02);
    rd_addr[0] = 5'd4; rd_addr[1] = 5'd9;
    tick();
    at_neg();
    check("multi_busy_pending", 64'(busy_count), 64'd2);
    @(posedge clk); #1;
    cdb(1, 6'h02, 64'h77); cdb(0, 6'h3F, 64'h99);
    at_neg();
    chk_rd("multi_fwd_rd4", 0, 1'b0, 64'h77);
    chk_rd("multi_fwd_rd9", 1, 1'b0, 64'h77);
    @(posedge clk); #1;
    idle();
    at_neg();
    chk_rd("multi_rd4", 0, 1'b0, 64'h77);
    chk_rd("multi_rd9", 1, 1'b0, 64'h77);
    check("multi_busy", 64'(busy_count), 64'd0);

    // Two CDB ports with the same tag: port 0 wins.
    @(posedge clk); #1;
    wr(0, 10, 1'b1, 64'h05);
    rd_addr[0] = 5'd10;
    tick();
    @(posedge clk); #1;
    cdb(0, 6'h05, 64'h10); cdb(1, 6'h05, 64'h20);
    at_neg();
    chk_rd("cdbprio_fwd", 0, 1'b0, 64'h10);
    @(posedge clk); #1;
    idle();
    at_neg();
    chk_rd("cdbprio_rd10", 0, 1'b0, 64'h10);

    // Write beats CDB on the same entry.
    @(posedge clk); #1;
    wr(0, 5, 1'b1, 64'h03);
    rd_addr[0] = 5'd5;
    tick();
    @(posedge clk); #1;
    cdb(0, 6'h03, 64'h55); wr(0, 5, 1'b1, 64'h04);
    at_neg();
    chk_rd("wbeat_fwd_no_wr", 0, 1'b0, 64'h55);
    check("wbeat_busy_before", 64'(busy_count), 64'd1);
    @(posedge clk); #1;
    idle();
    at_neg();
    chk_rd("wbeat_rd5", 0, 1'b1, 64'h04);
    check("wbeat_busy", 64'(busy_count), 64'd1);

    // Zero register ignores plain and virtual writes.
    @(posedge clk); #1;
    wr(0, 0, 1'b0, 64'hFF);
    rd_addr[1] = 5'd0;
    tick();
    at_neg();
    chk_rd("zero_plain", 1, 1'b0, 64'h0);
    @(posedge clk); #1;
    wr(0, 0, 1'b1, 64'hFF);
    tick();
    at_neg();
    chk_rd("zero_virtual", 1, 1'b0, 64'h0);
    check("zero_busy", 64'(busy_count), 64'd1);

    // Five pending entries, then asynchronous reset mid-cycle.
    @(posedge clk); #1;
    wr(0, 11, 1'b1, 64'h20); wr(1, 12, 1'b1, 64'h21);
    tick();
    wr(0, 13, 1'b1, 64'h22); wr(1, 14, 1'b1, 64'h23);
    rd_addr[1] = 5'd11;
    tick();
    at_neg();
    check("pre_reset_busy", 64'(busy_count), 64'd5);
    chk_rd("pre_reset_rd11", 1, 1'b1, 64'h20);
    cdb(0, 6'h04, 64'hDEAD);
    rst = 1'b1;
    #2;
    chk_rd("async_reset_rd5", 0, 1'b0, 64'h0);
    chk_rd("async_reset_rd11", 1, 1'b0, 64'h0);
    check("async_reset_busy", 64'(busy_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    at_neg();
    chk_rd("post_reset_rd5", 0, 1'b0, 64'h0);
    check("post_reset_busy", 64'(busy_count), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
